// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// Imported by the interface, the controller and the testbench.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
// master = requester, slave = controller.
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_dataflow.sv
// Shared 1-bit full adder datapath.
// Purely combinational; time-shared by the serial controller.
module full_adder_dataflow (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder step per clock, LSB first.
// Result registers update only on the completion edge.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] ps_q;
  logic [WIDTH-1:0] ps_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;

  logic fa_s;
  logic fa_co;
  logic last;
  logic accept;
  logic busy;
  logic done;

  full_adder_dataflow u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_co)
  );

  assign last   = (cnt_q == LAST);
  assign accept = (state_q != RUN) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == RUN):  busy = 1'b1;
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps
  always_comb begin
    ps_d = ps_q >> 1;
    ps_d[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      sa_q    <= bus.a;
      sb_q    <= bus.b;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sa_q    <= sa_q >> 1;
      sb_q    <= sb_q >> 1;
      ps_q    <= ps_d;
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        sum_q  <= ps_d;
        cout_q <= fa_co;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
// Expected results come from plain a+b+cin arithmetic and cycle counting.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_sum = '0;
  logic       exp_cout = 1'b0;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drop_at >= 0 pulses a spurious start during that busy sample
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic c, input int drop_at);
    logic [8:0] r;
    r = 9'(a) + 9'(b) + 9'(c);
    if8.start = 1'b1;
    if8.a = a;
    if8.b = b;
    if8.cin = c;
    step();
    for (int i = 0; i < 8; i++) begin
      if8.start = (i == drop_at);
      if8.a = (i == drop_at) ? 8'h10 : 8'($urandom);
      if8.b = 8'($urandom);
      if8.cin = 1'($urandom);
      chk("busy_run", 32'(if8.busy), 32'd1);
      chk("done_run", 32'(if8.done), 32'd0);
      chk("hold_run", {23'd0, if8.cout, if8.sum}, {23'd0, exp_cout, exp_sum});
      step();
    end
    if8.start = 1'b0;
    chk("done_pulse", 32'(if8.done), 32'd1);
    chk("busy_done", 32'(if8.busy), 32'd0);
    chk("sum", 32'(if8.sum), 32'(r[7:0]));
    chk("cout", 32'(if8.cout), 32'(r[8]));
    exp_sum = r[7:0];
    exp_cout = r[8];
  endtask

  task automatic idle8();
    if8.start = 1'b0;
    step();
    chk("done_idle", 32'(if8.done), 32'd0);
    chk("busy_idle", 32'(if8.busy), 32'd0);
    chk("hold_idle", {23'd0, if8.cout, if8.sum}, {23'd0, exp_cout, exp_sum});
  endtask

  initial begin
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    #1;
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_sum", 32'(if8.sum), 32'd0);
    chk("rst_cout", 32'(if8.cout), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(if8.busy), 32'd0);

    op8(8'h5A, 8'h3C, 1'b0, -1);
    idle8();
    op8(8'hFF, 8'h01, 1'b0, -1);
    idle8();
    op8(8'hFF, 8'hFF, 1'b1, -1);
    idle8();
    op8(8'h01, 8'h01, 1'b0, 2);
    idle8();
    op8(8'h0F, 8'h01, 1'b0, -1);
    op8(8'h20, 8'h02, 1'b0, -1);
    idle8();

    for (int n = 0; n < 30; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), -1);
      if ($urandom_range(1, 0) == 1) idle8();
    end
    idle8();

    // abort mid-run
    if8.start = 1'b1;
    if8.a = 8'hC3;
    if8.b = 8'h7E;
    if8.cin = 1'b1;
    step();
    if8.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_rst_busy", 32'(if8.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(if8.busy), 32'd0);
    chk("abort_done", 32'(if8.done), 32'd0);
    chk("abort_sum", 32'(if8.sum), 32'd0);
    chk("abort_cout", 32'(if8.cout), 32'd0);
    exp_sum = '0;
    exp_cout = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("no_done_after_abort", 32'(if8.done), 32'd0);
    end
    chk("abort_hold", {23'd0, if8.cout, if8.sum}, 32'd0);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      logic [1:0] r1;
      v = 3'(k);
      r1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      if1.start = 1'b1;
      if1.a = v[2];
      if1.b = v[1];
      if1.cin = v[0];
      step();
      if1.start = 1'b0;
      if1.a = 1'($urandom);
      if1.b = 1'($urandom);
      chk("w1_busy", 32'(if1.busy), 32'd1);
      chk("w1_done_early", 32'(if1.done), 32'd0);
      step();
      chk("w1_done", 32'(if1.done), 32'd1);
      chk("w1_res", {30'd0, if1.cout, if1.sum}, {30'd0, r1});
      step();
      chk("w1_idle", 32'(if1.done), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
